// File: rtl/pattern_checker_pkg.sv
// Shared definitions for the data-pattern checker and any future pattern
// generator. It holds the mode encodings, the default LFSR taps, the
// zero-seed substitute and the first-error capture record.
package pattern_checker_pkg;

   typedef enum logic [1:0] {
      MODE_FIXED = 2'd0,
      MODE_INC   = 2'd1,
      MODE_ROTL  = 2'd2,
      MODE_LFSR  = 2'd3
   } mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Galois taps for the LFSR mode.
   localparam logic [31:0] LFSR_POLY_DEFAULT = 32'h8020_0003;
   // An all-zero LFSR would stay at zero forever, so a zero seed loads this value instead.
   localparam logic [31:0] LFSR_ZERO_SEED    = 32'h0000_0001;

   // Snapshot of the first mismatching word.
   typedef struct packed {
      logic [31:0] index;
      logic [31:0] data;
      logic [31:0] expected;
   } err_rec_t;

endpackage

// File: rtl/pattern_next.sv
// Combinational next-value function of the test pattern. The checker and a
// future generator both use it, so the two always step the pattern the same way.
// Ports:
//   mode    - pattern type (fixed / increment / rotate-left / LFSR)
//   current - current pattern word
//   next    - following pattern word
module pattern_next
   import pattern_checker_pkg::*;
#(
   parameter logic [31:0] LFSR_POLY = LFSR_POLY_DEFAULT
) (
   input  mode_e       mode,
   input  logic [31:0] current,
   output logic [31:0] next
);

   always_comb begin
      next = current;
      case (mode)
         MODE_FIXED: next = current;
         MODE_INC:   next = current + 32'd1;
         MODE_ROTL:  next = {current[30:0], current[31]};
         // Galois step: shift right, fold the taps in when a 1 falls out.
         MODE_LFSR:  next = {1'b0, current[31:1]} ^ (current[0] ? LFSR_POLY : 32'd0);
         default:    next = current;
      endcase
   end

endmodule

// File: rtl/pattern_checker.sv
// Checks a stream of words from the upstream FIFO against a locally generated
// pattern. A reload pulse arms the checker and restarts the pattern from the
// seed. Every valid word in RUN is compared, counted, and the pattern advances.
// Error statistics stay across reloads and are zeroed only by clear_errors or reset.
// Ports:
//   okClk, reset            - clock; synchronous active-high reset
//   data_in, data_valid     - word from the FIFO and its valid strobe (no back-pressure)
//   seed, mode, reload      - pattern setup, sampled when reload is high
//   clear_errors            - zero the error statistics
//   armed                   - high while in RUN
//   word_count              - words checked since the last reload (wraps)
//   error_count             - mismatching words (saturates)
//   error_flag              - sticky first-mismatch flag
//   first_err_*             - index, data and expected value of the first mismatch
module pattern_checker
   import pattern_checker_pkg::*;
#(
   parameter logic [31:0] LFSR_POLY = LFSR_POLY_DEFAULT
) (
   input  logic        okClk,
   input  logic        reset,
   input  logic [31:0] data_in,
   input  logic        data_valid,
   input  logic [31:0] seed,
   input  logic [1:0]  mode,
   input  logic        reload,
   input  logic        clear_errors,
   output logic        armed,
   output logic [31:0] word_count,
   output logic [31:0] error_count,
   output logic        error_flag,
   output logic [31:0] first_err_index,
   output logic [31:0] first_err_data,
   output logic [31:0] first_err_expected
);

   state_e      state_q, state_d;
   mode_e       mode_q;
   logic [31:0] expected_q;
   logic [31:0] expected_nxt;
   logic [31:0] word_cnt_q;
   logic [31:0] err_cnt_q;
   logic        err_flag_q;
   err_rec_t    err_rec_q;

   logic        word_chk;
   logic        mismatch;
   logic [31:0] seed_eff;

   pattern_next #(
      .LFSR_POLY (LFSR_POLY)
   ) u_next (
      .mode    (mode_q),
      .current (expected_q),
      .next    (expected_nxt)
   );

   // A word that arrives together with reload is dropped.
   assign word_chk = (state_q == ST_RUN) && data_valid && !reload;
   assign mismatch = word_chk && (data_in != expected_q);
   assign seed_eff = (mode_e'(mode) == MODE_LFSR && seed == 32'd0) ? LFSR_ZERO_SEED : seed;

   // FSM: only reset leaves RUN.
   always_ff @(posedge okClk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (reload) state_d = ST_RUN;
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_IDLE;
      endcase
   end

   // Pattern tracking and word counter.
   always_ff @(posedge okClk) begin
      if (reset) begin
         mode_q     <= MODE_FIXED;
         expected_q <= 32'd0;
         word_cnt_q <= 32'd0;
      end else if (reload) begin
         mode_q     <= mode_e'(mode);
         expected_q <= seed_eff;
         word_cnt_q <= 32'd0;
      end else if (word_chk) begin
         expected_q <= expected_nxt;
         word_cnt_q <= word_cnt_q + 32'd1;
      end
   end

   // Error statistics. A clear in the same cycle as a mismatch clears first
   // and then records the new mismatch, so that word becomes the first error.
   always_ff @(posedge okClk) begin
      if (reset) begin
         err_cnt_q  <= 32'd0;
         err_flag_q <= 1'b0;
         err_rec_q  <= '0;
      end else if (clear_errors) begin
         err_cnt_q  <= mismatch ? 32'd1 : 32'd0;
         err_flag_q <= mismatch;
         err_rec_q  <= mismatch ? '{index: word_cnt_q, data: data_in, expected: expected_q} : '0;
      end else if (mismatch) begin
         if (err_cnt_q != 32'hFFFF_FFFF) err_cnt_q <= err_cnt_q + 32'd1;
         if (!err_flag_q) begin
            err_flag_q <= 1'b1;
            err_rec_q  <= '{index: word_cnt_q, data: data_in, expected: expected_q};
         end
      end
   end

   assign armed              = (state_q == ST_RUN);
   assign word_count         = word_cnt_q;
   assign error_count        = err_cnt_q;
   assign error_flag         = err_flag_q;
   assign first_err_index    = err_rec_q.index;
   assign first_err_data     = err_rec_q.data;
   assign first_err_expected = err_rec_q.expected;

endmodule

// File: doc/pattern_checker.md
PATTERN_CHECKER -- requirements
Module: pattern_checker

Interface
REQ-001 SHALL have parameter LFSR_POLY, default 32'h80200003, Galois feedback taps for mode 3.
REQ-002 SHALL have port okClk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port data_in  input  32  word read from upstream FIFO (dout).
REQ-005 SHALL have port data_valid  input  1  data_in is a new word this cycle (FIFO valid).
REQ-006 SHALL have port seed  input  32  pattern start value, sampled on reload.
REQ-007 SHALL have port mode  input  2  pattern type, sampled on reload: 0 fixed, 1 increment, 2 rotate-left, 3 LFSR.
REQ-008 SHALL have port reload  input  1  one-cycle pulse; arm checker and restart pattern.
REQ-009 SHALL have port clear_errors  input  1  one-cycle pulse; clear error statistics.
REQ-010 SHALL have port armed  output  1  checker in RUN state.
REQ-011 SHALL have port word_count  output  32  words checked since last reload; wraps.
REQ-012 SHALL have port error_count  output  32  mismatching words; saturates at 32'hFFFFFFFF.
REQ-013 SHALL have port error_flag  output  1  sticky; set on first mismatch.
REQ-014 SHALL have port first_err_index  output  32  word_count value of first mismatching word.
REQ-015 SHALL have port first_err_data  output  32  received data of first mismatch.
REQ-016 SHALL have port first_err_expected  output  32  expected value of first mismatch.

Function
REQ-017 SHALL implement FSM with states IDLE and RUN; IDLE -> RUN on reload; RUN -> RUN on reload (restart); only reset returns to IDLE.
REQ-018 SHALL ignore data_valid in IDLE: no counting, no comparison.
REQ-019 SHALL on reload latch mode and set expected to seed, except mode 3 with seed==0, which loads 32'h00000001.
REQ-020 SHALL on reload clear word_count; error statistics untouched.
REQ-021 SHALL in RUN on data_valid compare data_in with expected, increment word_count, advance expected.
REQ-022 SHALL advance expected: mode 0 unchanged; mode 1 +1 mod 2^32; mode 2 rotate left 1; mode 3 shift right 1, XOR LFSR_POLY if shifted-out LSB was 1.
REQ-023 SHALL increment error_count on mismatch unless already 32'hFFFFFFFF.
REQ-024 SHALL on first mismatch while error_flag==0 capture first_err_index (pre-increment word_count), first_err_data, first_err_expected and set error_flag; later mismatches do not overwrite.
REQ-025 SHALL register all outputs; effect of a valid word visible in the cycle after data_valid (latency 1).
REQ-026 SHALL, on reload and data_valid in the same cycle, give reload priority; the word is discarded, not counted.
REQ-027 SHALL, on clear_errors alone, zero error_count, error_flag and all first_err_* outputs.
REQ-028 SHALL, on clear_errors with a mismatching valid word, leave error_count=1 and capture that word as first error.
REQ-029 SHALL accept data_valid every cycle with no back-pressure.

Reset
REQ-030 SHALL on reset enter IDLE and set every output to 0, expected to 0, latched mode to 0.
REQ-031 SHALL give reset priority over reload, clear_errors and data_valid, including mid-stream.

Structure
REQ-032 SHALL take mode encodings (MODE_FIXED, MODE_INC, MODE_ROTL, MODE_LFSR), default LFSR_POLY and LFSR zero-seed substitute from shared package pattern_checker_pkg.
REQ-033 SHALL implement next-expected computation in combinational sub-module pattern_next (inputs mode, current; output next), reusable by a future generator for the read test.

Verification
REQ-034 SHALL cover: mode 1, seed 0x00000010, reload, 8 valid words 0x10..0x17 -> word_count=8, error_count=0, error_flag=0.
REQ-035 SHALL cover: mode 2, seed 0x80000000, reload, words 0x80000000, 0x00000001, 0x00000003 -> error_count=1, first_err_index=2, first_err_data=0x00000003, first_err_expected=0x00000002.
REQ-036 SHALL cover: mode 3, seed 0, reload, 1000 words from reference model starting 0x00000001 -> error_count=0; second word equals 0x80200003 (shift 1 -> 0, XOR poly).
REQ-037 SHALL cover: reload and data_valid same cycle, then mode 0 seed 0xA5A5A5A5 words -> discarded word not counted, word_count equals later valid words only.
REQ-038 SHALL cover: error_count forced near max (0xFFFFFFFE via 3 mismatches after backdoor load) -> holds 0xFFFFFFFF; clear_errors with mismatch -> error_count=1.
REQ-039 SHALL cover: reset mid-stream after 5 words -> next cycle all outputs 0, armed=0, subsequent data_valid ignored until reload.
